// File: rtl/hex_scroll_display_if.sv
// Bus between the switch/key front end and the scrolling HEX driver.
// master drives the message-edit and scroll controls; slave returns the
// segment bank, the scroll position and the step pulse.
interface hex_scroll_display_if #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 8
);
    localparam int PW = $clog2(MSG_LEN);

    logic                    clear;
    logic                    wr_en;
    logic [2:0]              wr_char;
    logic                    run;
    logic                    dir;
    logic                    blink;
    logic [7*NUM_DIGITS-1:0] hex;
    logic [PW-1:0]           pos;
    logic                    tick;

    modport master (
        output clear, wr_en, wr_char, run, dir, blink,
        input  hex, pos, tick
    );

    modport slave (
        input  clear, wr_en, wr_char, run, dir, blink,
        output hex, pos, tick
    );
endinterface

// File: rtl/hex_scroll_display.sv
// Scrolling-message driver for the seven-segment bank.
// Holds a MSG_LEN-glyph message (appended one glyph per wr_en cycle) and
// rotates it across NUM_DIGITS active-low HEX displays once every TICK_DIV
// clocks while run is high. Optional blinking is built only when the macro
// HEX_SCROLL_BLINK_EN is defined; otherwise the blink input is ignored.
module hex_scroll_display #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    hex_scroll_display_if.slave   bus
);
    localparam int PW = $clog2(MSG_LEN);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(MSG_LEN - 1);
    localparam logic [PW:0]   LEN_WIDE  = (PW+1)'(MSG_LEN);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;

    // Glyph code to active-low segments, bit order g..a.
    function automatic logic [6:0] glyph_seg(input logic [2:0] code);
        logic [6:0] seg;
        case (code)
            3'd0:    seg = 7'h21; // d
            3'd1:    seg = 7'h06; // E
            3'd2:    seg = 7'h79; // 1
            3'd3:    seg = 7'h40; // 0
            3'd4:    seg = 7'h09; // H
            3'd5:    seg = 7'h47; // L
            3'd6:    seg = 7'h0C; // P
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic [2:0]              msg_reg [MSG_LEN];
    logic [PW-1:0]           pos_reg;
    logic [PW-1:0]           pos_next;
    logic [CW-1:0]           cnt_reg;
    logic                    tick_reg;
    logic [7*NUM_DIGITS-1:0] hex_reg;
    logic                    wrap;
    logic                    blank_all;
    logic [6:0]              digit_seg [NUM_DIGITS];

    // A scroll step happens on the cycle the running divider reaches its end.
    assign wrap = bus.run && (cnt_reg == CNT_LAST);

    // Tick divider: counts only while run is high; tick is the registered wrap.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (bus.clear) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= wrap;
            if (bus.run) begin
                cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    // Next scroll position; explicit wrap so non-power-of-two lengths work.
    always_comb begin
        pos_next = pos_reg;
        if (wrap) begin
            if (bus.dir) begin
                pos_next = (pos_reg == '0) ? POS_LAST : pos_reg - 1'b1;
            end else begin
                pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
            end
        end
    end

    // Scroll position register; clear overrides a coincident step.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pos_reg <= '0;
        end else if (bus.clear) begin
            pos_reg <= '0;
        end else begin
            pos_reg <= pos_next;
        end
    end

    // Message shift buffer: newest glyph enters at the top, oldest drops off.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < MSG_LEN; j++) begin
                msg_reg[j] <= 3'd7;
            end
        end else if (bus.clear) begin
            for (int j = 0; j < MSG_LEN; j++) begin
                msg_reg[j] <= 3'd7;
            end
        end else if (bus.wr_en) begin
            for (int j = 0; j < MSG_LEN - 1; j++) begin
                msg_reg[j] <= msg_reg[j+1];
            end
            msg_reg[MSG_LEN-1] <= bus.wr_char;
        end
    end

`ifdef HEX_SCROLL_BLINK_EN
    logic phase_reg;

    // Blink phase flips on every scroll step; clear restarts it visible.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            phase_reg <= 1'b0;
        end else if (bus.clear) begin
            phase_reg <= 1'b0;
        end else if (wrap) begin
            phase_reg <= ~phase_reg;
        end
    end

    assign blank_all = bus.blink && phase_reg;
`else
    assign blank_all = 1'b0;
`endif

    // Digit d shows msg[(pos + NUM_DIGITS-1-d) mod MSG_LEN]; the offset is a
    // constant per digit, so the modulo reduces to one conditional subtract.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam int OFF = (NUM_DIGITS - 1 - gi) % MSG_LEN;
            logic [PW:0]   sum;
            logic [PW-1:0] idx;
            assign sum = {1'b0, pos_reg} + (PW+1)'(OFF);
            assign idx = (sum >= LEN_WIDE) ? PW'(sum - LEN_WIDE) : PW'(sum);
            assign digit_seg[gi] = glyph_seg(msg_reg[idx]);
        end
    endgenerate

    // Registered segment outputs, one cycle behind msg/pos/phase.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hex_reg <= '1;
        end else begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                hex_reg[7*d +: 7] <= blank_all ? SEG_BLANK : digit_seg[d];
            end
        end
    end

    assign bus.hex  = hex_reg;
    assign bus.pos  = pos_reg;
    assign bus.tick = tick_reg;
endmodule

// File: tb/tb_hex_scroll_display.sv
// Directed bench for hex_scroll_display (6 digits, 8 glyphs, tick every 4).
// Build with +define+HEX_SCROLL_BLINK_EN to exercise the blink variant.
module tb_hex_scroll_display;
    localparam int ND = 6;
    localparam int ML = 8;
    localparam int TD = 4;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
    // Message d E 1 _ H E L P, HEX5 first.
    localparam logic [41:0] PAT_P0 = {7'h21, 7'h06, 7'h79, 7'h7F, 7'h09, 7'h06};
    localparam logic [41:0] PAT_P1 = {7'h06, 7'h79, 7'h7F, 7'h09, 7'h06, 7'h47};
    localparam logic [41:0] PAT_P7 = {7'h0C, 7'h21, 7'h06, 7'h79, 7'h7F, 7'h09};
    // After appending glyph 3 (0): msg = E 1 _ H E L P 0.
    localparam logic [41:0] PAT_W1 = {7'h79, 7'h7F, 7'h09, 7'h06, 7'h47, 7'h0C};
    localparam logic [41:0] PAT_W2 = {7'h7F, 7'h09, 7'h06, 7'h47, 7'h0C, 7'h40};
    // Only msg[7]=H, shown at pos 7 on HEX5.
    localparam logic [41:0] PAT_H7 = {7'h09, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hex_scroll_display_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();

    hex_scroll_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [2:0] c);
        bus.wr_en   = 1'b1;
        bus.wr_char = c;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        bus.clear = 0; bus.wr_en = 0; bus.wr_char = 0;
        bus.run = 0; bus.dir = 0; bus.blink = 0;
        resetn = 1'b0;
        repeat (3) step();
        total++; if (bus.hex !== ALL_BLANK) begin bad++; $display("FAIL reset_hex got=%h want=%h", bus.hex, ALL_BLANK); end
        total++; if (bus.pos !== 3'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", bus.pos); end
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", bus.tick); end
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL idle_tick cycle=%0d got=%b want=0", i, bus.tick); end
        end
        total++; if (bus.pos !== 3'd0) begin bad++; $display("FAIL idle_pos got=%0d want=0", bus.pos); end
        $display("test_reset done");
    endtask

    task automatic test_write();
        logic [2:0] codes [8];
        codes = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd1, 3'd5, 3'd6};
        for (int i = 0; i < 8; i++) write_char(codes[i]);
        step();
        total++; if (bus.hex !== PAT_P0) begin bad++; $display("FAIL write_hex got=%h want=%h", bus.hex, PAT_P0); end
        total++; if (bus.pos !== 3'd0) begin bad++; $display("FAIL write_pos got=%0d want=0", bus.pos); end
        $display("test_write done");
    endtask

    task automatic test_scroll_left();
        bus.dir = 1'b0;
        bus.run = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            total++;
            if (bus.tick !== ((i % TD) == 0)) begin bad++; $display("FAIL left_tick cycle=%0d got=%b want=%b", i, bus.tick, (i % TD) == 0); end
            if (i == 4) begin
                total++; if (bus.pos !== 3'd1) begin bad++; $display("FAIL left_pos1 got=%0d want=1", bus.pos); end
            end
            if (i == 5) begin
                total++; if (bus.hex !== PAT_P1) begin bad++; $display("FAIL left_hex1 got=%h want=%h", bus.hex, PAT_P1); end
            end
            if (i == 32) begin
                total++; if (bus.pos !== 3'd0) begin bad++; $display("FAIL left_wrap_pos got=%0d want=0", bus.pos); end
                bus.run = 1'b0;
            end
        end
        step();
        total++; if (bus.hex !== PAT_P0) begin bad++; $display("FAIL left_wrap_hex got=%h want=%h", bus.hex, PAT_P0); end
        $display("test_scroll_left done");
    endtask

    task automatic test_scroll_right();
        bus.dir = 1'b1;
        bus.run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (bus.tick !== (i == 4)) begin bad++; $display("FAIL right_tick cycle=%0d got=%b want=%b", i, bus.tick, i == 4); end
        end
        total++; if (bus.pos !== 3'd7) begin bad++; $display("FAIL right_pos got=%0d want=7", bus.pos); end
        bus.run = 1'b0;
        step();
        total++; if (bus.hex !== PAT_P7) begin bad++; $display("FAIL right_hex got=%h want=%h", bus.hex, PAT_P7); end
        $display("test_scroll_right done");
    endtask

    task automatic test_hold();
        // dir still 1 here; flip it while frozen so the next step goes left.
        bus.run = 1'b1;
        repeat (2) step();
        bus.run = 1'b0;
        bus.dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL hold_tick cycle=%0d got=%b want=0", i, bus.tick); end
        end
        bus.run = 1'b1;
        step();
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL resume_early_tick got=%b want=0", bus.tick); end
        step();
        total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL resume_tick got=%b want=1", bus.tick); end
        total++; if (bus.pos !== 3'd0) begin bad++; $display("FAIL resume_pos got=%0d want=0", bus.pos); end
        bus.run = 1'b0;
        step();
        total++; if (bus.hex !== PAT_P0) begin bad++; $display("FAIL resume_hex got=%h want=%h", bus.hex, PAT_P0); end
        $display("test_hold done");
    endtask

    task automatic test_same_cycle();
        bus.dir = 1'b0;
        bus.run = 1'b1;
        repeat (3) step();
        bus.wr_en = 1'b1; bus.wr_char = 3'd3;
        step();
        bus.wr_en = 1'b0;
        total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL wrtick_tick got=%b want=1", bus.tick); end
        total++; if (bus.pos !== 3'd1) begin bad++; $display("FAIL wrtick_pos got=%0d want=1", bus.pos); end
        bus.run = 1'b0;
        step();
        total++; if (bus.hex !== PAT_W1) begin bad++; $display("FAIL wrtick_hex1 got=%h want=%h", bus.hex, PAT_W1); end
        bus.run = 1'b1;
        repeat (4) step();
        bus.run = 1'b0;
        total++; if (bus.pos !== 3'd2) begin bad++; $display("FAIL wrtick_pos2 got=%0d want=2", bus.pos); end
        step();
        total++; if (bus.hex !== PAT_W2) begin bad++; $display("FAIL wrtick_hex2 got=%h want=%h", bus.hex, PAT_W2); end
        // clear together with a write and a wrapping divider
        bus.run = 1'b1;
        repeat (3) step();
        bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_char = 3'd4;
        step();
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.run = 1'b0;
        total++; if (bus.pos !== 3'd0) begin bad++; $display("FAIL clear_pos got=%0d want=0", bus.pos); end
        step();
        total++; if (bus.hex !== ALL_BLANK) begin bad++; $display("FAIL clear_hex got=%h want=%h", bus.hex, ALL_BLANK); end
        // divider restarted from 0; step right so msg[7] lands on HEX5
        bus.dir = 1'b1;
        bus.run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (bus.tick !== (i == 4)) begin bad++; $display("FAIL clear_cnt_tick cycle=%0d got=%b want=%b", i, bus.tick, i == 4); end
        end
        bus.run = 1'b0;
        total++; if (bus.pos !== 3'd7) begin bad++; $display("FAIL clear_after_pos got=%0d want=7", bus.pos); end
        step();
        total++; if (bus.hex !== ALL_BLANK) begin bad++; $display("FAIL clear_drops_write got=%h want=%h", bus.hex, ALL_BLANK); end
        $display("test_same_cycle done");
    endtask

    task automatic test_async_reset();
        write_char(3'd4);
        step();
        total++; if (bus.hex !== PAT_H7) begin bad++; $display("FAIL pre_reset_hex got=%h want=%h", bus.hex, PAT_H7); end
        bus.dir = 1'b0;
        bus.run = 1'b1;
        repeat (2) step();
        #3 resetn = 1'b0;
        #1;
        total++; if (bus.hex !== ALL_BLANK) begin bad++; $display("FAIL async_hex got=%h want=%h", bus.hex, ALL_BLANK); end
        total++; if (bus.pos !== 3'd0) begin bad++; $display("FAIL async_pos got=%0d want=0", bus.pos); end
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL async_tick got=%b want=0", bus.tick); end
        bus.run = 1'b0;
        step();
        resetn = 1'b1;
        repeat (3) step();
        bus.run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (bus.tick !== (i == 4)) begin bad++; $display("FAIL post_reset_tick cycle=%0d got=%b want=%b", i, bus.tick, i == 4); end
        end
        bus.run = 1'b0;
        total++; if (bus.pos !== 3'd1) begin bad++; $display("FAIL post_reset_pos got=%0d want=1", bus.pos); end
        $display("test_async_reset done");
    endtask

    task automatic test_blink();
        logic blanked;
        logic expect_blank;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        for (int c = 0; c < 6; c++) write_char(3'(c));
        step();
        bus.dir = 1'b0;
        bus.blink = 1'b1;
        bus.run = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            blanked = (bus.hex === ALL_BLANK);
`ifdef HEX_SCROLL_BLINK_EN
            expect_blank = (((i - 1) / TD) % 2) == 1;
`else
            expect_blank = 1'b0;
`endif
            total++; if (blanked !== expect_blank) begin bad++; $display("FAIL blink cycle=%0d blanked=%b want=%b hex=%h", i, blanked, expect_blank, bus.hex); end
        end
        bus.run = 1'b0;
        bus.blink = 1'b0;
        $display("test_blink done");
    endtask

    initial begin
        test_reset();
        test_write();
        test_scroll_left();
        test_scroll_right();
        test_hold();
        test_same_cycle();
        test_async_reset();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_scroll_display.md
# hex_scroll_display

Parametrised scrolling-message driver for the DE-series seven-segment bank. It holds a MSG_LEN-character message written one glyph at a time, for example from SW and a KEY strobe. On a divided-down tick it rotates that message across NUM_DIGITS HEX displays, left or right. It sits under the board `top`, between debounced switch/key inputs and the HEX0..HEXn outputs, and replaces the static, switch-selected rotation of earlier labs.

## Interface
Parameters:
- NUM_DIGITS, 6: number of HEX displays driven; legal range 1..6.
- MSG_LEN, 8: message buffer depth in characters; must be 2 or more; any relation to NUM_DIGITS is allowed.
- TICK_DIV, 50_000_000: CLOCK_50 cycles per scroll step; must be 2 or more.

Ports (PW = clog2(MSG_LEN)):
- CLOCK_50  in  1  sole clock; every register is rising-edge triggered.
- resetn  in  1  asynchronous, active-low reset; `top` wires KEY[0] to it.
- clear  in  1  synchronous clear of the message and the position.
- wr_en  in  1  appends wr_char to the message; one character per cycle while high.
- wr_char  in  3  glyph code.
- run  in  1  1 lets the tick divider count and the message scroll; 0 freezes both.
- dir  in  1  0 scrolls left (pos increments); 1 scrolls right (pos decrements).
- blink  in  1  blink request; ignored unless HEX_SCROLL_BLINK_EN is defined.
- hex  out  7*NUM_DIGITS  active-low segments. Digit d occupies hex[7d+6:7d]; d=0 is HEX0 (rightmost). Bit order within a digit is g..a (bit6=g, bit0=a).
- pos  out  PW  current scroll position.
- tick  out  1  one-cycle pulse on each scroll step.

## Operation
- Glyph codes and their segment values:
  - 0 = d (0x21)
  - 1 = E (0x06)
  - 2 = 1 (0x79)
  - 3 = 0 (0x40)
  - 4 = H (0x09)
  - 5 = L (0x47)
  - 6 = P (0x0C)
  - 7 = blank (0x7F)
- Message buffer msg[0..MSG_LEN-1], each entry 3 bits.
  - A write shifts msg[j] <= msg[j+1] and loads msg[MSG_LEN-1] <= wr_char, so the oldest character drops off.
- Divider:
  - cnt counts 0..TICK_DIV-1 while run=1 and holds while run=0.
  - When cnt = TICK_DIV-1 and run=1, tick=1 and cnt wraps to 0.
- Position update on tick:
  - dir=0: pos <= (pos+1) mod MSG_LEN.
  - dir=1: pos <= pos-1, wrapping 0 -> MSG_LEN-1.
- Mapping: digit d shows msg[(pos + NUM_DIGITS-1-d) mod MSG_LEN], so the leftmost digit shows msg[pos].
  - When MSG_LEN < NUM_DIGITS, the message repeats across the displays.
- Priority within one cycle:
  - clear beats wr_en and tick: all msg entries become 7, pos becomes 0, cnt becomes 0.
  - wr_en and tick in the same cycle: both take effect. The shift uses the pre-tick buffer and pos still advances.
- Reset values:
  - msg all 7, pos 0, cnt 0, tick 0, blink phase 0.
  - hex all ones (every segment 0x7F).

## Timing
- hex is a register computed from the current msg, pos and blink phase.
- An input event (wr_en, clear, tick) sampled at edge k updates msg/pos at edge k; hex reflects the change at edge k+1.
- tick is registered. It is high for exactly the cycle after the edge at which cnt wraps, and pos changes at that same wrap edge.
- With run held at 1, tick period = TICK_DIV cycles exactly.
- Deasserting run mid-count holds cnt; reasserting run resumes from the held value with no extra tick.
- Reset mid-scroll returns to the reset state asynchronously. The first tick after release comes TICK_DIV cycles after the first run=1 edge.
- Changing dir takes effect at the next tick; no extra step is taken.

## Configuration
- HEX_SCROLL_BLINK_EN defined:
  - A phase bit toggles on every tick.
  - While blink=1 and phase=1, every digit is driven to 0x7F; otherwise digits show their normal glyphs.
  - clear and reset force phase to 0.
- Not defined:
  - No phase register is built; the blink port is present but ignored.
  - hex always shows the mapped glyphs.

## Test plan
All scenarios use NUM_DIGITS=6, MSG_LEN=8, TICK_DIV=4.
- Reset: resetn=0 mid-count -> hex all 0x7F, pos=0, tick=0 immediately; after release with run=0, no tick ever occurs.
- Write codes 0,1,2,7,4,1,5,6 with run=0 -> one cycle after the last write, HEX5..HEX0 = 0x21, 0x06, 0x79, 0x7F, 0x09, 0x06.
- Scroll left from that message, run=1, dir=0 -> tick every 4 cycles; after the first tick pos=1 and HEX5=0x06; after 8 ticks pos=0 again and the first display pattern is restored.
- Scroll right from pos=0 with dir=1 -> one tick gives pos=7, HEX5=0x0C, HEX4=0x21.
- Same-cycle events: wr_en with wr_char=3 in a tick cycle -> pos advances and msg[7]=3. clear together with wr_en and tick -> hex all 0x7F and pos=0.
- Blink (macro on), blink=1, run=1 -> hex alternates between the glyph pattern and all 0x7F every 4 cycles. Macro off -> hex is never fully blanked by blink.
